// File: rtl/ula_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ula_seq : handshaked ALU, registered result/flags, bit-serial variable shifts
// Rev 1.0
// ----------------------------------------------------------------------------
module ula_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [4:0] c_OP_ADD    = 5'b00000;
  localparam logic [4:0] c_OP_ADDINC = 5'b00001;
  localparam logic [4:0] c_OP_INCA   = 5'b00011;
  localparam logic [4:0] c_OP_SUBDEC = 5'b00100;
  localparam logic [4:0] c_OP_SUB    = 5'b00101;
  localparam logic [4:0] c_OP_DECA   = 5'b00110;
  localparam logic [4:0] c_OP_LSL1   = 5'b01000;
  localparam logic [4:0] c_OP_ASR1   = 5'b01001;
  localparam logic [4:0] c_OP_LSLV   = 5'b01010;
  localparam logic [4:0] c_OP_LSRV   = 5'b01011;
  localparam logic [4:0] c_OP_ASRV   = 5'b01100;

  localparam logic [1:0] c_SH_LSL = 2'b10;
  localparam logic [1:0] c_SH_LSR = 2'b11;

  localparam logic [SHW-1:0] c_CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] c_CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_sop;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;
  logic             r_illegal;

  logic             w_accept;
  logic [SHW-1:0]   w_amt;
  logic             w_start_shift;

  logic [WIDTH-1:0] w_op2;
  logic             w_cin;
  logic             w_arith;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_illegal;
  logic             w_vshift;

  logic [WIDTH-1:0] w_sh_acc;
  logic             w_sh_out;

  // Logic-op map, indexed by the low opcode nibble when opcode[4] = 1.
  always_comb begin
    w_logic = '0;
    case (opcode[3:0])
      4'h0:    w_logic = '0;
      4'h1:    w_logic = a & b;
      4'h2:    w_logic = ~a & b;
      4'h3:    w_logic = b;
      4'h4:    w_logic = a & ~b;
      4'h5:    w_logic = a;
      4'h6:    w_logic = a ^ b;
      4'h7:    w_logic = a | b;
      4'h8:    w_logic = ~a & ~b;
      4'h9:    w_logic = ~(a ^ b);
      4'hA:    w_logic = ~a;
      4'hB:    w_logic = ~a | b;
      4'hC:    w_logic = ~b;
      4'hD:    w_logic = a | ~b;
      4'hE:    w_logic = ~a | ~b;
      default: w_logic = '1;
    endcase
  end

  always_comb begin
    w_op2     = b;
    w_cin     = 1'b0;
    w_arith   = 1'b0;
    w_res     = '0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    w_vshift  = 1'b0;
    case (opcode)
      c_OP_ADD:    w_arith = 1'b1;
      c_OP_ADDINC: begin w_arith = 1'b1; w_cin = 1'b1; end
      c_OP_INCA:   begin w_arith = 1'b1; w_op2 = '0; w_cin = 1'b1; end
      c_OP_SUBDEC: begin w_arith = 1'b1; w_op2 = ~b; end
      c_OP_SUB:    begin w_arith = 1'b1; w_op2 = ~b; w_cin = 1'b1; end
      c_OP_DECA:   begin w_arith = 1'b1; w_op2 = '1; end
      c_OP_LSL1: begin
        w_res   = {a[WIDTH-2:0], 1'b0};
        w_carry = a[WIDTH-1];
      end
      c_OP_ASR1: begin
        w_res   = {a[WIDTH-1], a[WIDTH-1:1]};
        w_carry = a[0];
      end
      // Zero-amount variable shifts complete immediately with result = a.
      c_OP_LSLV, c_OP_LSRV, c_OP_ASRV: begin
        w_vshift = 1'b1;
        w_res    = a;
      end
      default: begin
        if (opcode[4]) begin
          w_res = w_logic;
        end else begin
          w_illegal = 1'b1;
        end
      end
    endcase
    w_sum = {1'b0, a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin};
    w_ovf = w_arith & (a[WIDTH-1] == w_op2[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
    if (w_arith) begin
      w_res   = w_sum[WIDTH-1:0];
      w_carry = w_sum[WIDTH];
    end
  end

  // One bit of the serial shift; r_sop holds opcode[1:0] of the captured op.
  always_comb begin
    w_sh_acc = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    w_sh_out = r_acc[0];
    case (r_sop)
      c_SH_LSL: begin
        w_sh_acc = {r_acc[WIDTH-2:0], 1'b0};
        w_sh_out = r_acc[WIDTH-1];
      end
      c_SH_LSR: begin
        w_sh_acc = {1'b0, r_acc[WIDTH-1:1]};
        w_sh_out = r_acc[0];
      end
      default: begin
        w_sh_acc = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        w_sh_out = r_acc[0];
      end
    endcase
  end

  assign w_amt         = b[SHW-1:0];
  assign w_accept      = in_valid & in_ready;
  assign w_start_shift = w_vshift & (w_amt != c_CNT_ZERO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid & rst_n) begin
          w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sop     <= '0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_illegal <= w_illegal;
            r_ovf     <= w_ovf;
            if (w_start_shift) begin
              r_acc   <= a;
              r_cnt   <= w_amt;
              r_sop   <= opcode[1:0];
              r_carry <= 1'b0;
            end else begin
              r_acc   <= w_res;
              r_carry <= w_carry;
              r_zero  <= (w_res == '0);
              r_neg   <= w_res[WIDTH-1];
            end
          end
        end
        S_SHIFT: begin
          r_acc   <= w_sh_acc;
          r_carry <= w_sh_out;
          r_cnt   <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_zero <= (w_sh_acc == '0);
            r_neg  <= w_sh_acc[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = r_acc;
  assign zero    = r_zero;
  assign neg     = r_neg;
  assign carry   = r_carry;
  assign ovf     = r_ovf;
  assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// tb_ula_seq: directed self-checking bench for ula_seq (32-bit and 8-bit builds).
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [4:0]  opcode;
  logic        zero, neg, carry, ovf, illegal;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [4:0]  opcode8;
  logic        zero8, neg8, carry8, ovf8, illegal8;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  f;   // {carry, ovf, neg, zero, illegal}
  } alu_vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    int          lat;
  } sh_vec_t;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  ula_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .opcode    (opcode8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .result    (result8),
    .zero      (zero8),
    .neg       (neg8),
    .carry     (carry8),
    .ovf       (ovf8),
    .illegal   (illegal8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from the accepting edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(input int max_cyc, output int lat, output bit rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < max_cyc) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || in_ready8 !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_in_ready cycle %0d: got %b/%b exp 0/0", i, in_ready, in_ready8);
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10 || result !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready %b out_valid %b result %h exp 1 0 00000000",
               in_ready, out_valid, result);
    end
    n_checks++;
    if ({zero, neg, carry, ovf, illegal} !== 5'b00000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b exp 00000", {zero, neg, carry, ovf, illegal});
    end
    n_checks++;
    if ({in_ready8, out_valid8} !== 2'b10 || result8 !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_w8: in_ready %b out_valid %b result %h exp 1 0 00",
               in_ready8, out_valid8, result8);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(5'b00000, 32'h7FFF_FFFF, 32'h1);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL add_ovf: out_valid %b result %h exp 1 80000000", out_valid, result);
    end
    n_checks++;
    if ({neg, ovf, carry, zero} !== 4'b1100) begin
      n_errors++;
      $display("FAIL add_ovf_flags: {neg,ovf,carry,zero} got %b exp 1100", {neg, ovf, carry, zero});
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL issue_interval: in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
    issue(5'b00101, 32'h5, 32'h5);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 || {zero, carry, neg, ovf} !== 4'b1100) begin
      n_errors++;
      $display("FAIL sub_eq: valid %b result %h {z,c,n,v} %b exp 1 00000000 1100",
               out_valid, result, {zero, carry, neg, ovf});
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_arith_logic();
    alu_vec_t tbl [20];
    int lat;
    bit rs;
    tbl[0]  = '{5'b00001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 5'b00000};
    tbl[1]  = '{5'b00001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5'b01100};
    tbl[2]  = '{5'b00011, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 5'b10010};
    tbl[3]  = '{5'b00100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 5'b10000};
    tbl[4]  = '{5'b00101, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b11000};
    tbl[5]  = '{5'b00110, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 5'b00100};
    tbl[6]  = '{5'b00110, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 5'b11000};
    tbl[7]  = '{5'b01000, 32'h8000_0001, 32'h0000_0000, 32'h0000_0002, 5'b10000};
    tbl[8]  = '{5'b01001, 32'h8000_0003, 32'h0000_0000, 32'hC000_0001, 5'b10100};
    tbl[9]  = '{5'b10001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00100};
    tbl[10] = '{5'b10110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000};
    tbl[11] = '{5'b11110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 5'b00000};
    tbl[12] = '{5'b11000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 5'b00000};
    tbl[13] = '{5'b10000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 5'b00010};
    tbl[14] = '{5'b11111, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 5'b00100};
    tbl[15] = '{5'b10010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0F00_0F00, 5'b00000};
    tbl[16] = '{5'b11101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0FF_F0FF, 5'b00100};
    tbl[17] = '{5'b10011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFF00_FF00, 5'b00100};
    tbl[18] = '{5'b00010, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 5'b00011};
    tbl[19] = '{5'b01111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 5'b00011};
    for (int i = 0; i < 20; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_valid(4, lat, rs);
      n_checks++;
      if (lat !== 1) begin
        n_errors++;
        $display("FAIL op_latency[%0d] op %b: got %0d exp 1", i, tbl[i].op, lat);
      end
      n_checks++;
      if (result !== tbl[i].r || {carry, ovf, neg, zero, illegal} !== tbl[i].f) begin
        n_errors++;
        $display("FAIL op_result[%0d] op %b: result %h flags %b exp %h %b", i, tbl[i].op,
                 result, {carry, ovf, neg, zero, illegal}, tbl[i].r, tbl[i].f);
      end
      retire();
    end
  endtask

  task automatic test_var_shift();
    sh_vec_t tbl [7];
    int lat;
    bit rs;
    logic [4:0] exp_f;
    tbl[0] = '{5'b01100, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 1'b0, 5};
    tbl[1] = '{5'b01100, 32'h8000_0010, 32'h0000_0000, 32'h8000_0010, 1'b0, 1};
    tbl[2] = '{5'b01011, 32'h0000_00F0, 32'h0000_0024, 32'h0000_000F, 1'b0, 5};
    tbl[3] = '{5'b01011, 32'hC000_0000, 32'h0000_001F, 32'h0000_0001, 1'b1, 32};
    tbl[4] = '{5'b01010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 2};
    tbl[5] = '{5'b01010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};
    tbl[6] = '{5'b01100, 32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b1, 32};
    for (int i = 0; i < 7; i++) begin
      exp_f = {tbl[i].c, 1'b0, tbl[i].r[31], (tbl[i].r == 32'h0), 1'b0};
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_valid(40, lat, rs);
      n_checks++;
      if (lat !== tbl[i].lat || rs !== 1'b0) begin
        n_errors++;
        $display("FAIL shift_latency[%0d]: got %0d in_ready_seen %b exp %0d 0", i, lat, rs, tbl[i].lat);
      end
      n_checks++;
      if (result !== tbl[i].r || {carry, ovf, neg, zero, illegal} !== exp_f) begin
        n_errors++;
        $display("FAIL shift_result[%0d]: result %h flags %b exp %h %b", i, result,
                 {carry, ovf, neg, zero, illegal}, tbl[i].r, exp_f);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rs;
    issue(5'b01010, 32'h0000_0003, 32'h0000_001F);
    wait_valid(40, lat, rs);
    n_checks++;
    if (lat !== 32 || rs !== 1'b0 || result !== 32'h8000_0000 || carry !== 1'b1) begin
      n_errors++;
      $display("FAIL lsl31: lat %0d rdy_seen %b result %h carry %b exp 32 0 80000000 1",
               lat, rs, result, carry);
    end
    in_valid = 1'b1;
    opcode   = 5'b00000;
    a        = 32'h1111_1111;
    b        = 32'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h8000_0000 ||
          {carry, neg, zero, ovf} !== 4'b1100) begin
        n_errors++;
        $display("FAIL hold[%0d]: valid %b in_ready %b result %h {c,n,z,v} %b exp 1 0 80000000 1100",
                 i, out_valid, in_ready, result, {carry, neg, zero, ovf});
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL release_hold: out_valid %b in_ready %b exp 0 1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL no_same_cycle_accept: out_valid %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    int lat;
    bit rs;
    issue(5'b01010, 32'h0000_0001, 32'h0000_0014);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 32'h0 || carry !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_shift_reset: valid %b in_ready %b result %h carry %b exp 0 0 00000000 0",
               out_valid, in_ready, result, carry);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0 || result !== 32'h0) begin
      n_errors++;
      $display("FAIL discarded_op: out_valid cycles %0d result %h exp 0 00000000", seen, result);
    end
    issue(5'b00000, 32'h2, 32'h3);
    wait_valid(4, lat, rs);
    n_checks++;
    if (lat !== 1 || result !== 32'h5) begin
      n_errors++;
      $display("FAIL add_after_reset: lat %0d result %h exp 1 00000005", lat, result);
    end
    retire();
  endtask

  task automatic test_width8();
    int lat;
    a8 = 8'hFF; b8 = 8'h01; opcode8 = 5'b00000; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    n_checks++;
    if (out_valid8 !== 1'b1 || result8 !== 8'h00 || {carry8, ovf8, neg8, zero8, illegal8} !== 5'b10010) begin
      n_errors++;
      $display("FAIL w8_add: valid %b result %h flags %b exp 1 00 10010",
               out_valid8, result8, {carry8, ovf8, neg8, zero8, illegal8});
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    a8 = 8'h80; b8 = 8'h0F; opcode8 = 5'b01100; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid8) lat = -1;
    n_checks++;
    if (lat !== 8 || result8 !== 8'hFF || {carry8, ovf8, neg8, zero8, illegal8} !== 5'b00100) begin
      n_errors++;
      $display("FAIL w8_asr7: lat %0d result %h flags %b exp 8 FF 00100",
               lat, result8, {carry8, ovf8, neg8, zero8, illegal8});
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    opcode     = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    a8         = '0;
    b8         = '0;
    opcode8    = '0;
    test_reset();
    test_add_sub();
    test_arith_logic();
    test_var_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
